// File: rtl/if_stage_pkg.sv
// Definitions shared by the fetch stage and the CSR/trap unit: reset
// defaults, IF->ID bus layout and the redirect-priority encoding.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0033;

    localparam int IF_ID_BUS_W = 64;
    localparam int INST_MSB    = 63;
    localparam int INST_LSB    = 32;
    localparam int PC_MSB      = 31;
    localparam int PC_LSB      = 0;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_BR   = 2'd1,
        REDIR_TRAP = 2'd2
    } redir_src_e;

    // A trap always outranks a taken branch in the same cycle.
    function automatic redir_src_e redir_sel(input logic trap, input logic br);
        if (trap)
            return REDIR_TRAP;
        else if (br)
            return REDIR_BR;
        else
            return REDIR_NONE;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_inst_buf.sv
// Skid register for the fetched instruction: grabs the RAM output on the first
// stalled cycle so the presented instruction survives RAM output changes.
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        fs_valid_i,
    input  logic [31:0] rdata_i,
    output logic        buf_valid_o,
    output logic [31:0] inst_buf_o
);

    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        capture;

    assign capture = !req_i && fs_valid_i && !buf_valid_q;

    always_comb begin
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (req_i) begin
            buf_valid_d = 1'b0;
        end else if (capture) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    assign buf_valid_o = buf_valid_q;
    assign inst_buf_o  = inst_buf_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, 1-cycle instruction RAM request,
// IF->ID valid/allowin handshake and zero-bubble branch/trap redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   inst_ram_en,
    output logic [31:0]            inst_ram_addr,
    input  logic [31:0]            inst_ram_rdata,
    input  logic                   ds_allowin,
    output logic                   fs_to_ds_valid,
    output logic [IF_ID_BUS_W-1:0] if_id_bus_out,
    input  logic                   br_jmp_flag,
    input  logic [31:0]            br_target,
    input  logic                   trap_flag,
    input  logic [31:0]            trap_target
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        fs_valid_q, fs_valid_d;

    redir_src_e  redir_src;
    logic        redirect;
    logic [31:0] redir_raw;
    logic [31:0] redir_target;
    logic        fs_allowin;
    logic        req;
    logic [31:0] req_addr;
    logic        buf_valid;
    logic [31:0] inst_buf;
    logic [31:0] inst;

    always_comb begin
        redir_src = redir_sel(trap_flag, br_jmp_flag);
        case (redir_src)
            REDIR_TRAP: redir_raw = trap_target;
            REDIR_BR:   redir_raw = br_target;
            default:    redir_raw = '0;
        endcase
        redir_target = align_word(redir_raw);
    end

    assign redirect   = (redir_src != REDIR_NONE);
    assign fs_allowin = !fs_valid_q || ds_allowin || redirect;
    assign req        = !rst && fs_allowin;
    assign req_addr   = redirect ? redir_target : fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fs_pc_d    = fs_pc_q;
        fs_valid_d = fs_valid_q;
        if (req) begin
            fs_pc_d    = req_addr;
            fs_valid_d = 1'b1;
            fetch_pc_d = req_addr + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            fs_pc_q    <= '0;
            fs_valid_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fs_pc_q    <= fs_pc_d;
            fs_valid_q <= fs_valid_d;
        end
    end

    if_inst_buf u_inst_buf (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .fs_valid_i  (fs_valid_q),
        .rdata_i     (inst_ram_rdata),
        .buf_valid_o (buf_valid),
        .inst_buf_o  (inst_buf)
    );

    // Reset also masks the stage so stale RAM data is never shown.
    always_comb begin
        if (rst || !fs_valid_q)
            inst = NOP_INST;
        else if (buf_valid)
            inst = inst_buf;
        else
            inst = inst_ram_rdata;
    end

    assign inst_ram_en    = req;
    assign inst_ram_addr  = req_addr;
    assign fs_to_ds_valid = fs_valid_q && !redirect && !rst;
    assign if_id_bus_out  = {inst, fs_pc_q};

endmodule
